// File: rtl/branch_predictor_pkg.sv
// Shared 2-bit branch-history counter encodings for the fetch-side predictor.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_e;

endpackage

// File: rtl/branch_predictor_bp_sat_counter.sv
// Next-state cell for one 2-bit up/down saturating branch-history counter.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != BP_ST)
                ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != BP_SNT)
                ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT+BTB predictor with EX-stage training and redirect.
// Optional statistics counters are enabled by defining BRANCH_PRED_STATS_EN.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
`ifdef BRANCH_PRED_STATS_EN
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts,
`endif
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = XLEN - IDX_BITS - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]    if_tag, ex_tag;
    logic                if_hit;
    logic [XLEN-1:0]     ex_pc_plus4;
    logic [1:0]          ex_ctr_next;
    logic                unused_pc_bits;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_BITS+2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign ex_tag = ex_pc[XLEN-1:IDX_BITS+2];
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // Lookup reads the registered tables, so a same-cycle update is not visible yet.
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + XLEN'(4));

    assign ex_pc_plus4 = ex_pc + XLEN'(4);

    always_comb begin
        redirect_valid = 1'b0;
        redirect_pc    = ex_pc_plus4;
        if (rst_n && ex_valid) begin
            if (ex_is_branch) begin
                if (ex_taken) begin
                    if (!ex_pred_taken || (ex_pred_target != ex_target)) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = ex_target;
                    end
                end else if (ex_pred_taken) begin
                    redirect_valid = 1'b1;
                end
            end else if (ex_pred_taken) begin
                // Non-branch predicted taken: an aliased BTB entry hit it.
                redirect_valid = 1'b1;
            end
        end
    end

    bp_sat_counter u_sat_counter (
        .ctr      (ctr_q[ex_idx]),
        .taken    (ex_taken),
        .ctr_next (ex_ctr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr_q[i] <= BP_WNT;
        end else if (ex_valid) begin
            if (ex_is_branch) begin
                ctr_q[ex_idx] <= ex_ctr_next;
                if (ex_taken)
                    valid_q[ex_idx] <= 1'b1;
            end else if (ex_pred_taken) begin
                valid_q[ex_idx] <= 1'b0;
            end
        end
    end

    // Tag/target are only meaningful behind valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (ex_valid && ex_is_branch && ex_taken) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= ex_target;
        end
    end

`ifdef BRANCH_PRED_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (ex_valid && ex_is_branch) begin
            stat_branches <= sat_inc32(stat_branches);
            if (redirect_valid)
                stat_mispredicts <= sat_inc32(stat_mispredicts);
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (lookup, training, redirect, alias, reset).
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    branch_predictor #(.XLEN(32), .IDX_BITS(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
`ifdef BRANCH_PRED_STATS_EN
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_ex(input logic v, input logic br, input logic [31:0] pc, input logic tk,
                            input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        ex_valid       = v;
        ex_is_branch   = br;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
        #1;
    endtask

    task automatic idle_ex();
        drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        if_pc = 32'h100;
        // Reset: a live mispredicting branch must still not redirect
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        step();
        step();
        check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_pred_target", pred_target, 32'h104);
        check("rst_redirect_forced0", {31'd0, redirect_valid}, 32'd0);
        idle_ex();
        rst_n = 1'b1;
        step();

        // Scenario 2: first taken branch mispredicted, then trained
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        check("s2_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("s2_redirect_pc", redirect_pc, 32'h80);
        step();
        idle_ex();
        check("s2_pred_taken", {31'd0, pred_taken}, 32'd1);
        check("s2_pred_target", pred_target, 32'h80);

        // Correctly predicted taken branch: ctr 10 -> 11
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        check("ok_no_redirect", {31'd0, redirect_valid}, 32'd0);
        step();
`ifdef BRANCH_PRED_STATS_EN
        check("stat_branches_2", stat_branches, 32'd2);
        check("stat_mispred_1", stat_mispredicts, 32'd1);
`endif
        // Scenario 3: saturate at 11, then one not-taken -> 10
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        step();
        drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        check("s3_nt_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("s3_nt_redirect_pc", redirect_pc, 32'h104);
        step();
        idle_ex();
        check("s3_still_taken", {31'd0, pred_taken}, 32'd1);
        check("s3_target", pred_target, 32'h80);

        // Taken, predicted taken but to a stale target
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
        check("bad_tgt_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("bad_tgt_redirect_pc", redirect_pc, 32'h90);
        step();
        idle_ex();
        check("bad_tgt_new_target", pred_target, 32'h90);

        // Scenario 4: non-branch alias at 0x200 evicts the 0x100 entry
        drive_ex(1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 1'b1, 32'h90);
        check("s4_alias_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("s4_alias_redirect_pc", redirect_pc, 32'h204);
        step();
        idle_ex();
        check("s4_evicted_miss", {31'd0, pred_taken}, 32'd0);
        check("s4_evicted_target", pred_target, 32'h104);
        drive_ex(1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 1'b0, 32'h204);
        check("nonbranch_no_redirect", {31'd0, redirect_valid}, 32'd0);
        step();

        // Scenario 5: same-index lookup and update -> old result this cycle
        // ctr is 11 (eviction leaves it); taken keeps 11
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
        check("s5_old_pred", {31'd0, pred_taken}, 32'd0);
        check("s5_old_target", pred_target, 32'h104);
        step();
        idle_ex();
        check("s5_new_pred", {31'd0, pred_taken}, 32'd1);
        check("s5_new_target", pred_target, 32'h40);

        // Decrement 11 -> 10 -> 01 -> 00, then one taken -> 01 (still not taken)
        drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
        step();
        drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
        check("dec_same_cycle_old", {31'd0, pred_taken}, 32'd1);
        step();
        drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
        check("dec_ctr01_pred", {31'd0, pred_taken}, 32'd0);
        check("dec_ctr01_redirect_pc", redirect_pc, 32'h104);
        step();
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
        step();
        idle_ex();
        check("sat_min_pred", {31'd0, pred_taken}, 32'd0);

        // PC+4 wraps
        if_pc = 32'hFFFF_FFFC;
        drive_ex(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h8);
        check("wrap_pred_target", pred_target, 32'h0);
        check("wrap_redirect_pc", redirect_pc, 32'h0);
        step();
        idle_ex();
        if_pc = 32'h100;

        // Scenario 6: train to predict taken, then async reset mid-operation
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
        step();
        check("s6_trained", {31'd0, pred_taken}, 32'd1);
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h60, 1'b0, 32'h104);
        check("s6_pre_rst_redirect", {31'd0, redirect_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("s6_rst_redirect0", {31'd0, redirect_valid}, 32'd0);
        check("s6_rst_miss", {31'd0, pred_taken}, 32'd0);
        check("s6_rst_target", pred_target, 32'h104);
`ifdef BRANCH_PRED_STATS_EN
        check("s6_stat_branches0", stat_branches, 32'd0);
        check("s6_stat_mispred0", stat_mispredicts, 32'd0);
`endif
        step();
        idle_ex();
        rst_n = 1'b1;
        step();
        check("s6_post_rst_miss", {31'd0, pred_taken}, 32'd0);
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        check("s6_first_redirect", {31'd0, redirect_valid}, 32'd1);
        step();
        drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        check("s6_second_ok", {31'd0, redirect_valid}, 32'd0);
        step();
        idle_ex();
`ifdef BRANCH_PRED_STATS_EN
        check("s6_stat_branches2", stat_branches, 32'd2);
        check("s6_stat_mispred1", stat_mispredicts, 32'd1);
`endif
        check("s6_final_pred", {31'd0, pred_taken}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
